mc_decoder: RTL

- Multicycle control unit for the ARM-subset CPU. It sits directly upstream of the conditional-write logic.
- Decodes Op/Funct/Rd from the instruction register and runs the main multicycle FSM.
- Produces the unconditional requests FlagW, PCS, RegW and MemW, which the conditional stage gates with CondEx. It also produces the datapath mux selects and the ALU control.

---
 rtl/mc_decoder_pkg.sv | 45 ++++
 rtl/mc_mainfsm.sv | 111 +++++++++++
 rtl/mc_decoder.sv | 71 +++++++
 3 files changed

// File: rtl/mc_decoder_pkg.sv
// Shared types and encodings for the multicycle control unit.
// State enum, opcode classes, ALU codes and datapath select values.
package mc_decoder_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mc_mainfsm.sv
// Main multicycle FSM: state register, next-state logic, Moore outputs.
// Enables are forced low combinationally while reset is asserted.
module mc_mainfsm
    import mc_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic       funct_i,
    input  logic       funct_l,
    output logic       ir_write,
    output logic       next_pc,
    output logic       adr_src,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_w,
    output logic       mem_w,
    output logic       branch,
    output logic       alu_op,
    output logic       undef
);

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = FETCH;
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        adr_src    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        undef      = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                state_d    = DECODE;
            end
            DECODE: begin
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                case (op)
                    OP_MEM:  state_d = MEMADR;
                    OP_DP:   state_d = funct_i ? EXECUTEI : EXECUTER;
                    OP_BR:   state_d = BRANCH;
                    default: state_d = UNKNOWN;
                endcase
            end
            MEMADR: begin
                alu_src_b = SRCB_IMM;
                state_d   = funct_l ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
            end
            MEMWR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            EXECUTER: begin
                alu_op  = 1'b1;
                state_d = ALUWB;
            end
            EXECUTEI: begin
                alu_src_b = SRCB_IMM;
                alu_op    = 1'b1;
                state_d   = ALUWB;
            end
            ALUWB: reg_w = 1'b1;
            BRANCH: begin
                alu_src_a  = SRCA_ALUOUT;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                branch     = 1'b1;
            end
            UNKNOWN: undef = 1'b1;
            default: state_d = FETCH;
        endcase
        // Reset parks the FSM in FETCH, whose own enables must stay quiet.
        if (!reset) begin
            ir_write = 1'b0;
            next_pc  = 1'b0;
            reg_w    = 1'b0;
            mem_w    = 1'b0;
            branch   = 1'b0;
            alu_op   = 1'b0;
            undef    = 1'b0;
        end
    end

endmodule

// File: rtl/mc_decoder.sv
// Multicycle control unit: main FSM plus ALU, PCS and instruction decode.
// Requests are unconditional; the downstream stage gates them with CondEx.
module mc_decoder
    import mc_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic       Undef
);

    logic branch;
    logic alu_op;

    mc_mainfsm u_fsm (
        .clk        (clk),
        .reset      (reset),
        .op         (Op),
        .funct_i    (Funct[5]),
        .funct_l    (Funct[0]),
        .ir_write   (IRWrite),
        .next_pc    (NextPC),
        .adr_src    (AdrSrc),
        .result_src (ResultSrc),
        .alu_src_a  (ALUSrcA),
        .alu_src_b  (ALUSrcB),
        .reg_w      (RegW),
        .mem_w      (MemW),
        .branch     (branch),
        .alu_op     (alu_op),
        .undef      (Undef)
    );

    always_comb begin
        ALUControl = ALU_ADD;
        FlagW      = 2'b00;
        if (alu_op) begin
            case (Funct[4:1])
                CMD_ADD: ALUControl = ALU_ADD;
                CMD_SUB: ALUControl = ALU_SUB;
                CMD_AND: ALUControl = ALU_AND;
                CMD_ORR: ALUControl = ALU_ORR;
                default: ALUControl = ALU_ADD;
            endcase
            // C,V only mean something for arithmetic results.
            FlagW[1] = Funct[0];
            FlagW[0] = Funct[0] & ((ALUControl == ALU_ADD) |
                                   (ALUControl == ALU_SUB));
        end
    end

    assign PCS    = (RegW & (Rd == 4'hF)) | branch;
    assign ImmSrc = Op;
    assign RegSrc = {Op == OP_MEM, Op == OP_BR};

endmodule
